// File: rtl/lsu_axi_master.sv
`default_nettype none
//==============================================================================
// Module   : lsu_axi_master
// Brief    : Load/store unit bridge from a single-outstanding execute-stage
//            request port to an AXI4-Lite style master. Loads are extended
//            per size/signedness, stores are lane-shifted with byte strobes.
// Ports    : clk, rst (sync, active-high)
//            req_*   : request from execute (valid/ready, we, size, unsigned,
//                      addr, wdata)
//            resp_*  : result to write-back (valid/ready, rdata, err)
//            maxi_ar*/r*/aw*/w*/b* : AXI read/write channels, 32-bit data
// Macros   : LSU_MISALIGN_TRAP_EN - when defined, misaligned half/word
//            accesses complete immediately with resp_err=1 and no bus
//            activity; otherwise they go out on the bus with truncated lanes.
// Revision : 1.0 - initial release
//==============================================================================
module lsu_axi_master #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // request from execute stage
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  // response to write-back stage
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  // AXI read address
  output logic [ADDR_W-1:0] maxi_araddr,
  output logic              maxi_arvalid,
  input  logic              maxi_arready,
  // AXI read data
  input  logic [31:0]       maxi_rdata,
  input  logic [1:0]        maxi_rresp,
  input  logic              maxi_rvalid,
  output logic              maxi_rready,
  // AXI write address
  output logic [ADDR_W-1:0] maxi_awaddr,
  output logic              maxi_awvalid,
  input  logic              maxi_awready,
  // AXI write data
  output logic [31:0]       maxi_wdata,
  output logic [3:0]        maxi_wstrb,
  output logic              maxi_wvalid,
  input  logic              maxi_wready,
  // AXI write response
  input  logic [1:0]        maxi_bresp,
  input  logic              maxi_bvalid,
  output logic              maxi_bready
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_DATA = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_RESP = 3'd4,
    S_RESP    = 3'd5
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_unsigned;
  logic [31:0]       r_wdata;     // already shifted onto its byte lanes
  logic [3:0]        r_wstrb;
  logic              r_aw_done;
  logic              r_w_done;
  logic [31:0]       r_rdata;
  logic              r_err;

  logic              w_accept;
  logic              w_trap;
  logic [3:0]        w_strb_base;
  logic [31:0]       w_rshift;
  logic [31:0]       w_load_ext;
  logic              w_unused_ok;

  // Only bit 1 of xRESP distinguishes SLVERR/DECERR from OKAY/EXOKAY.
  assign w_unused_ok = ^{maxi_rresp[0], maxi_bresp[0]};

  assign w_accept = (r_state == S_IDLE) && req_valid;

`ifdef LSU_MISALIGN_TRAP_EN
  // Half needs bit 0 clear; word (size 2 or 3) needs both low bits clear.
  assign w_trap = ((req_size == 2'd1) && req_addr[0]) ||
                  (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign w_trap = 1'b0;
`endif

  always_comb begin
    w_strb_base = 4'b1111;
    case (req_size)
      2'd0:    w_strb_base = 4'b0001;
      2'd1:    w_strb_base = 4'b0011;
      default: w_strb_base = 4'b1111;
    endcase
  end

  // Bring the addressed byte lane down to bit 0, then extend.
  assign w_rshift = maxi_rdata >> {r_addr[1:0], 3'b000};

  always_comb begin
    w_load_ext = w_rshift;
    case (r_size)
      2'd0: w_load_ext = r_unsigned ? {24'd0, w_rshift[7:0]}
                                    : {{24{w_rshift[7]}}, w_rshift[7:0]};
      2'd1: w_load_ext = r_unsigned ? {16'd0, w_rshift[15:0]}
                                    : {{16{w_rshift[15]}}, w_rshift[15:0]};
      default: w_load_ext = w_rshift;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    maxi_arvalid = 1'b0;
    maxi_rready  = 1'b0;
    maxi_awvalid = 1'b0;
    maxi_wvalid  = 1'b0;
    maxi_bready  = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (w_trap)      w_next = S_RESP;
          else if (req_we) w_next = S_WR_REQ;
          else             w_next = S_RD_ADDR;
        end
      end
      S_RD_ADDR: begin
        maxi_arvalid = 1'b1;
        if (maxi_arready) w_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        maxi_rready = 1'b1;
        if (maxi_rvalid) w_next = S_RESP;
      end
      S_WR_REQ: begin
        // AW and W complete independently; leave once both have been taken.
        maxi_awvalid = !r_aw_done;
        maxi_wvalid  = !r_w_done;
        if ((r_aw_done || maxi_awready) && (r_w_done || maxi_wready))
          w_next = S_WR_RESP;
      end
      S_WR_RESP: begin
        maxi_bready = 1'b1;
        if (maxi_bvalid) w_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request capture and result datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_addr     <= '0;
      r_size     <= 2'd0;
      r_unsigned <= 1'b0;
      r_wdata    <= 32'd0;
      r_wstrb    <= 4'd0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_rdata    <= 32'd0;
      r_err      <= 1'b0;
    end else if (w_accept) begin
      r_addr     <= req_addr;
      r_size     <= req_size;
      r_unsigned <= req_unsigned;
      r_wdata    <= req_wdata << {req_addr[1:0], 3'b000};
      r_wstrb    <= w_strb_base << req_addr[1:0];
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_rdata    <= 32'd0;
      r_err      <= w_trap;
    end else if (r_state == S_WR_REQ) begin
      if (maxi_awready) r_aw_done <= 1'b1;
      if (maxi_wready)  r_w_done  <= 1'b1;
    end else if ((r_state == S_RD_DATA) && maxi_rvalid) begin
      r_rdata <= w_load_ext;
      r_err   <= maxi_rresp[1];
    end else if ((r_state == S_WR_RESP) && maxi_bvalid) begin
      r_err <= maxi_bresp[1];
    end
  end

  assign maxi_araddr = {r_addr[ADDR_W-1:2], 2'b00};
  assign maxi_awaddr = {r_addr[ADDR_W-1:2], 2'b00};
  assign maxi_wdata  = r_wdata;
  assign maxi_wstrb  = r_wstrb;
  assign resp_rdata  = r_rdata;
  assign resp_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_axi_master.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : tb_lsu_axi_master
// Brief    : Directed bench for lsu_axi_master. A reactive AXI slave with
//            per-transaction delays; expectations come from an arithmetic
//            model of load extension / store lane placement, checked every
//            cycle by one monitor, plus literal checks on key vectors.
// Revision : 1.0 - initial release
//==============================================================================
module tb_lsu_axi_master;

  localparam int ADDR_W = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] maxi_araddr, maxi_awaddr, maxi_rdata, maxi_wdata;
  logic        maxi_arvalid, maxi_arready, maxi_rvalid, maxi_rready;
  logic        maxi_awvalid, maxi_awready, maxi_wvalid, maxi_wready;
  logic        maxi_bvalid, maxi_bready;
  logic [1:0]  maxi_rresp, maxi_bresp;
  logic [3:0]  maxi_wstrb;

  always #5 clk = ~clk;

  lsu_axi_master #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .maxi_araddr(maxi_araddr), .maxi_arvalid(maxi_arvalid), .maxi_arready(maxi_arready),
    .maxi_rdata(maxi_rdata), .maxi_rresp(maxi_rresp), .maxi_rvalid(maxi_rvalid),
    .maxi_rready(maxi_rready),
    .maxi_awaddr(maxi_awaddr), .maxi_awvalid(maxi_awvalid), .maxi_awready(maxi_awready),
    .maxi_wdata(maxi_wdata), .maxi_wstrb(maxi_wstrb), .maxi_wvalid(maxi_wvalid),
    .maxi_wready(maxi_wready),
    .maxi_bresp(maxi_bresp), .maxi_bvalid(maxi_bvalid), .maxi_bready(maxi_bready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_bytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] bus, input logic [31:0] addr,
                                         input logic [1:0] size, input logic uns);
    logic [31:0] v;
    int          nb;
    v  = bus >> (8 * addr[1:0]);
    nb = m_bytes(size);
    if (nb == 4) return v;
    v = v & ((32'd1 << (8 * nb)) - 32'd1);
    if (!uns && (v >= (32'd1 << (8 * nb - 1)))) v = v - (32'd1 << (8 * nb));
    return v;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [31:0] addr);
    return d << (8 * addr[1:0]);
  endfunction

  function automatic logic [3:0] m_wstrb(input logic [1:0] size, input logic [31:0] addr);
    logic [31:0] s;
    s = ((32'd1 << m_bytes(size)) - 32'd1) << addr[1:0];
    return s[3:0];
  endfunction

  function automatic bit m_trap(input logic [1:0] size, input logic [31:0] addr);
`ifdef LSU_MISALIGN_TRAP_EN
    return (addr % m_bytes(size)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- transaction table ----------------
  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] data;   // store data, or slave read data for loads
    logic [1:0]  resp;
    int          ar_d, r_d, aw_d, w_d, b_d, hold;
    bit          zw;     // zero-wait slave and resp_ready=1
  } txn_t;

  function automatic txn_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] data,
                              input logic [1:0] resp, input int ar_d, input int r_d,
                              input int aw_d, input int w_d, input int b_d, input int hold);
    txn_t t;
    t.we = we; t.size = size; t.uns = uns; t.addr = addr; t.data = data; t.resp = resp;
    t.ar_d = ar_d; t.r_d = r_d; t.aw_d = aw_d; t.w_d = w_d; t.b_d = b_d; t.hold = hold;
    t.zw = (ar_d == 0) && (r_d == 0) && (aw_d == 0) && (w_d == 0) && (b_d == 0) && (hold == 0);
    return t;
  endfunction

  // ---------------- slave configuration / expectations ----------------
  int          cfg_ar_d, cfg_r_d, cfg_aw_d, cfg_w_d, cfg_b_d;
  logic [31:0] cfg_rdata;
  logic [1:0]  cfg_rresp, cfg_bresp;

  bit          exp_active = 1'b0;
  bit          exp_we, exp_trap;
  logic [31:0] exp_araddr, exp_wdata, exp_rdata;
  logic [3:0]  exp_wstrb;
  logic        exp_err;
  int          txn_id = 0;

  // monitor-owned observations
  int          n_ar = 0, n_aw = 0, n_w = 0, n_b = 0, n_resp = 0, n_rc = 0;
  int          last_bus_id = -1;
  logic [31:0] cap_araddr, cap_awaddr, cap_wdata, cap_rdata;
  logic [3:0]  cap_wstrb;
  logic        cap_err;

  // ---------------- AXI slave: read side ----------------
  initial begin
    logic hs;
    int   g;
    maxi_arready = 1'b0; maxi_rvalid = 1'b0; maxi_rdata = 32'd0; maxi_rresp = 2'd0;
    forever begin
      @(negedge clk);
      if (maxi_arvalid && !rst) begin
        repeat (cfg_ar_d) @(negedge clk);
        maxi_arready = 1'b1;
        @(posedge clk); #1 maxi_arready = 1'b0;
        for (int k = 0; k < cfg_r_d; k++) begin @(posedge clk); #1; end
        maxi_rvalid = 1'b1; maxi_rdata = cfg_rdata; maxi_rresp = cfg_rresp;
        g = 0;
        do begin
          @(negedge clk); hs = maxi_rready && !rst; g++;
          @(posedge clk);
        end while (!hs && g < 30);
        #1 maxi_rvalid = 1'b0; maxi_rdata = 32'd0; maxi_rresp = 2'd0;
      end
    end
  end

  // ---------------- AXI slave: write side ----------------
  initial begin
    logic hs;
    int   g;
    maxi_awready = 1'b0; maxi_wready = 1'b0; maxi_bvalid = 1'b0; maxi_bresp = 2'd0;
    forever begin
      @(negedge clk);
      if (maxi_awvalid && !rst) begin
        fork
          begin
            repeat (cfg_aw_d) @(negedge clk);
            maxi_awready = 1'b1;
            @(posedge clk); #1 maxi_awready = 1'b0;
          end
          begin
            repeat (cfg_w_d) @(negedge clk);
            maxi_wready = 1'b1;
            @(posedge clk); #1 maxi_wready = 1'b0;
          end
        join
        for (int k = 0; k < cfg_b_d; k++) begin @(posedge clk); #1; end
        maxi_bvalid = 1'b1; maxi_bresp = cfg_bresp;
        g = 0;
        do begin
          @(negedge clk); hs = maxi_bready && !rst; g++;
          @(posedge clk);
        end while (!hs && g < 30);
        #1 maxi_bvalid = 1'b0; maxi_bresp = 2'd0;
      end
    end
  end

  // ---------------- per-cycle compare process ----------------
  always @(negedge clk) begin
    if (!rst) begin
      chk("ar_aw_exclusive", 32'(maxi_arvalid && maxi_awvalid), 32'd0);
      if (req_ready)
        chk("idle_outputs_quiet", 32'({maxi_arvalid, maxi_rready, maxi_awvalid,
                                       maxi_wvalid, maxi_bready, resp_valid}), 32'd0);
      if (maxi_arvalid) begin
        chk("ar_allowed", 32'(exp_active && !exp_we && !exp_trap), 32'd1);
        chk("araddr", maxi_araddr, exp_araddr);
        cap_araddr = maxi_araddr;
        if (maxi_arready) n_ar++;
      end
      if (maxi_rvalid && maxi_rready) last_bus_id = txn_id;
      if (maxi_awvalid) begin
        chk("aw_allowed", 32'(exp_active && exp_we && !exp_trap), 32'd1);
        chk("awaddr", maxi_awaddr, exp_araddr);
        cap_awaddr = maxi_awaddr;
        if (maxi_awready) n_aw++;
      end
      if (maxi_wvalid) begin
        chk("w_allowed", 32'(exp_active && exp_we && !exp_trap), 32'd1);
        chk("wdata", maxi_wdata, exp_wdata);
        chk("wstrb", 32'(maxi_wstrb), 32'(exp_wstrb));
        cap_wdata = maxi_wdata;
        cap_wstrb = maxi_wstrb;
        if (maxi_wready) n_w++;
      end
      if (maxi_bvalid && maxi_bready) begin
        n_b++;
        last_bus_id = txn_id;
      end
      if (resp_valid) begin
        chk("resp_expected", 32'(exp_active), 32'd1);
        chk("resp_after_bus", 32'((last_bus_id == txn_id) || exp_trap), 32'd1);
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", 32'(resp_err), 32'(exp_err));
        cap_rdata = resp_rdata;
        cap_err   = resp_err;
        n_rc++;
        if (resp_ready) n_resp++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic run(input txn_t t);
    logic acc;
    int   g, lat;
    bit   seen;
    int   b_resp, b_ar, b_aw, b_w, b_b, b_rc;
    exp_trap   = m_trap(t.size, t.addr);
    cfg_ar_d = t.ar_d; cfg_r_d = t.r_d; cfg_aw_d = t.aw_d; cfg_w_d = t.w_d; cfg_b_d = t.b_d;
    cfg_rdata = t.data; cfg_rresp = t.resp; cfg_bresp = t.resp;
    exp_we     = t.we;
    exp_araddr = {t.addr[31:2], 2'b00};
    exp_wdata  = m_wdata(t.data, t.addr);
    exp_wstrb  = m_wstrb(t.size, t.addr);
    exp_rdata  = (exp_trap || t.we) ? 32'd0 : m_load(t.data, t.addr, t.size, t.uns);
    exp_err    = exp_trap ? 1'b1 : t.resp[1];
    txn_id++;
    exp_active = 1'b1;
    b_resp = n_resp; b_ar = n_ar; b_aw = n_aw; b_w = n_w; b_b = n_b; b_rc = n_rc;

    resp_ready   = (t.hold == 0);
    req_valid    = 1'b1;
    req_we       = t.we;
    req_size     = t.size;
    req_unsigned = t.uns;
    req_addr     = t.addr;
    req_wdata    = t.data;
    g = 0;
    do begin
      @(negedge clk); acc = req_ready; g++;
      @(posedge clk);
    end while (!acc && g < 20);
    chk("req_accepted", 32'(acc), 32'd1);
    #1 req_valid = 1'b0;

    lat = 0; seen = 1'b0;
    while (!seen && lat < 60) begin
      @(negedge clk); lat++;
      if (resp_valid) seen = 1'b1;
    end
    chk("resp_seen", 32'(seen), 32'd1);
    if (t.zw) chk("resp_latency", lat, exp_trap ? 32'd1 : 32'd3);

    if (t.hold > 0) begin
      repeat (t.hold) @(posedge clk);
      #1 resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    repeat (2) @(posedge clk);
    #1;
    chk("resp_handshakes", n_resp - b_resp, 32'd1);
    chk("resp_valid_cycles", n_rc - b_rc, t.hold + 1);
    chk("ar_count", n_ar - b_ar, (!t.we && !exp_trap) ? 32'd1 : 32'd0);
    chk("aw_count", n_aw - b_aw, (t.we && !exp_trap) ? 32'd1 : 32'd0);
    chk("w_count",  n_w - b_w,   (t.we && !exp_trap) ? 32'd1 : 32'd0);
    chk("b_count",  n_b - b_b,   (t.we && !exp_trap) ? 32'd1 : 32'd0);
    chk("back_to_idle", 32'(req_ready), 32'd1);
    exp_active = 1'b0;
  endtask

  txn_t tv[12];

  initial begin
    logic seen_rd;
    int   b_resp;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b1;
    cfg_ar_d = 0; cfg_r_d = 0; cfg_aw_d = 0; cfg_w_d = 0; cfg_b_d = 0;
    cfg_rdata = 32'd0; cfg_rresp = 2'd0; cfg_bresp = 2'd0;
    exp_we = 1'b0; exp_trap = 1'b0; exp_araddr = 32'd0; exp_wdata = 32'd0;
    exp_rdata = 32'd0; exp_wstrb = 4'd0; exp_err = 1'b0;

    //            we    size   uns   addr           data           resp   ar r  aw w  b  hold
    tv[0]  = mk(1'b0, 2'd0, 1'b0, 32'h8000_0003, 32'h80FF_1234, 2'b00, 0, 0, 0, 0, 0, 0); // lb
    tv[1]  = mk(1'b1, 2'd1, 1'b0, 32'h8000_0002, 32'h0000_ABCD, 2'b00, 0, 0, 0, 0, 0, 0); // sh
    tv[2]  = mk(1'b1, 2'd2, 1'b0, 32'h4000_0008, 32'h1234_5678, 2'b00, 0, 0, 0, 3, 0, 0); // sw, W late
    tv[3]  = mk(1'b0, 2'd2, 1'b0, 32'h8000_0004, 32'hDEAD_BEEF, 2'b10, 0, 5, 0, 0, 0, 4); // lw, SLVERR
    tv[4]  = mk(1'b0, 2'd1, 1'b1, 32'h1000_0002, 32'h8765_ABCD, 2'b00, 0, 0, 0, 0, 0, 0); // lhu
    tv[5]  = mk(1'b0, 2'd1, 1'b0, 32'h1000_0000, 32'h1234_F00D, 2'b00, 1, 2, 0, 0, 0, 0); // lh
    tv[6]  = mk(1'b0, 2'd0, 1'b1, 32'h1000_0001, 32'h0000_A500, 2'b00, 0, 0, 0, 0, 0, 0); // lbu
    tv[7]  = mk(1'b1, 2'd0, 1'b0, 32'h2000_0001, 32'h1234_56EE, 2'b11, 0, 0, 2, 0, 1, 0); // sb, DECERR
    tv[8]  = mk(1'b0, 2'd2, 1'b0, 32'h8000_0001, 32'hAABB_CCDD, 2'b00, 0, 0, 0, 0, 0, 0); // lw misaligned
    tv[9]  = mk(1'b1, 2'd1, 1'b0, 32'h3000_0003, 32'h0000_1234, 2'b00, 0, 0, 0, 0, 0, 0); // sh misaligned
    tv[10] = mk(1'b0, 2'd3, 1'b1, 32'h5000_0000, 32'h0102_0304, 2'b00, 0, 0, 0, 0, 0, 0); // size 3
    tv[11] = mk(1'b1, 2'd2, 1'b0, 32'h6000_0010, 32'hCAFE_F00D, 2'b00, 0, 0, 2, 2, 0, 1); // sw, both late

    // model pins against hand-computed values
    chk("model_lb",   m_load(32'h80FF_1234, 32'h8000_0003, 2'd0, 1'b0), 32'hFFFF_FF80);
    chk("model_wstrb", 32'(m_wstrb(2'd1, 32'h8000_0002)), 32'h0000_000C);
    chk("model_lh",   m_load(32'h1234_F00D, 32'h1000_0000, 2'd1, 1'b0), 32'hFFFF_F00D);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready",  32'(req_ready), 32'd1);
    chk("rst_valids", 32'({resp_valid, maxi_arvalid, maxi_rready, maxi_awvalid,
                           maxi_wvalid, maxi_bready}), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err",   32'(resp_err), 32'd0);
    chk("rst_araddr",     maxi_araddr, 32'd0);
    chk("rst_awaddr",     maxi_awaddr, 32'd0);
    chk("rst_wdata",      maxi_wdata, 32'd0);
    chk("rst_wstrb",      32'(maxi_wstrb), 32'd0);
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run(tv[i]);
      if (i == 0) begin
        chk("lb_araddr_lit", cap_araddr, 32'h8000_0000);
        chk("lb_rdata_lit",  cap_rdata,  32'hFFFF_FF80);
        chk("lb_err_lit",    32'(cap_err), 32'd0);
      end
      if (i == 1) begin
        chk("sh_awaddr_lit", cap_awaddr, 32'h8000_0000);
        chk("sh_wdata_lit",  cap_wdata,  32'hABCD_0000);
        chk("sh_wstrb_lit",  32'(cap_wstrb), 32'h0000_000C);
      end
      if (i == 3) begin
        chk("lw_err_lit",   32'(cap_err), 32'd1);
        chk("lw_rdata_lit", cap_rdata, 32'hDEAD_BEEF);
      end
      if (i == 8) begin
`ifdef LSU_MISALIGN_TRAP_EN
        chk("mis_lw_err_lit",   32'(cap_err), 32'd1);
        chk("mis_lw_rdata_lit", cap_rdata, 32'd0);
`else
        chk("mis_lw_err_lit",   32'(cap_err), 32'd0);
        chk("mis_lw_rdata_lit", cap_rdata, 32'h00AA_BBCC);
`endif
      end
    end

    // Reset while the load waits in the data phase: no response may follow.
    cfg_ar_d = 0; cfg_r_d = 6; cfg_rdata = 32'h5555_AAAA; cfg_rresp = 2'b00;
    exp_we = 1'b0; exp_trap = 1'b0; exp_araddr = 32'h7000_0000;
    exp_rdata = 32'h5555_AAAA; exp_err = 1'b0;
    txn_id++;
    exp_active = 1'b1;
    b_resp = n_resp;
    resp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = 32'h7000_0000;
    @(posedge clk); #1 req_valid = 1'b0;
    seen_rd = 1'b0;
    for (int k = 0; k < 20 && !seen_rd; k++) begin
      @(negedge clk);
      if (maxi_rready) seen_rd = 1'b1;
    end
    chk("rst_test_reached_rdata", 32'(seen_rd), 32'd1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    exp_active = 1'b0;
    @(negedge clk);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_valids", 32'({resp_valid, maxi_arvalid, maxi_rready}), 32'd0);
    repeat (50) @(posedge clk);
    #1;
    chk("midrst_no_resp", n_resp - b_resp, 32'd0);
    chk("midrst_resp_rdata", resp_rdata, 32'd0);

    // Recovery after the abandoned transaction.
    run(mk(1'b0, 2'd0, 1'b0, 32'h9000_0002, 32'h007F_0000, 2'b00, 0, 0, 0, 0, 0, 0));
    chk("recover_rdata_lit", cap_rdata, 32'h0000_007F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/lsu_axi_master.md
LSU_AXI_MASTER -- requirements
Module: lsu_axi_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width of request and AXI address ports (data fixed 32 bits).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on posedge.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset.
REQ-004 SHALL have port req_valid  input  1  load/store request from execute stage.
REQ-005 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-006 SHALL have port req_we  input  1  1 store, 0 load.
REQ-007 SHALL have port req_size  input  2  0 byte, 1 half, 2 word (3 treated as word).
REQ-008 SHALL have port req_unsigned  input  1  load zero-extend when 1, sign-extend when 0.
REQ-009 SHALL have port req_addr  input  ADDR_W  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have ports resp_valid output 1 / resp_ready input 1  result handshake to write-back stage.
REQ-012 SHALL have ports resp_rdata output 32 (extended load data, 0 for stores) / resp_err output 1 (bus or alignment error).
REQ-013 SHALL have ports maxi_araddr output ADDR_W / maxi_arvalid output 1 / maxi_arready input 1  read address channel.
REQ-014 SHALL have ports maxi_rdata input 32 / maxi_rresp input 2 / maxi_rvalid input 1 / maxi_rready output 1  read data channel.
REQ-015 SHALL have ports maxi_awaddr output ADDR_W / maxi_awvalid output 1 / maxi_awready input 1  write address channel.
REQ-016 SHALL have ports maxi_wdata output 32 / maxi_wstrb output 4 / maxi_wvalid output 1 / maxi_wready input 1  write data channel.
REQ-017 SHALL have ports maxi_bresp input 2 / maxi_bvalid input 1 / maxi_bready output 1  write response channel.

Function
REQ-018 SHALL implement FSM IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP; req_ready high only in IDLE.
REQ-019 SHALL latch addr, size, unsigned, we, wdata on req_valid&&req_ready; go RD_ADDR (load) or WR_REQ (store).
REQ-020 SHALL in RD_ADDR drive arvalid=1, araddr={addr[ADDR_W-1:2],2'b00}, hold both stable until arready, then go RD_DATA.
REQ-021 SHALL in RD_DATA drive rready=1; on rvalid capture rdata>>(8*addr[1:0]), extend per size/unsigned, err=rresp[1], go RESP.
REQ-022 SHALL in WR_REQ assert awvalid and wvalid together, each dropping independently after its own handshake; go WR_RESP when both completed (same or different cycles).
REQ-023 SHALL drive awaddr word-aligned, wdata=req_wdata<<(8*addr[1:0]), wstrb=(byte 4'b0001, half 4'b0011, word 4'b1111)<<addr[1:0], truncated to 4 bits.
REQ-024 SHALL in WR_RESP drive bready=1; on bvalid set err=bresp[1], go RESP.
REQ-025 SHALL in RESP hold resp_valid=1 with stable resp_rdata/resp_err until resp_ready, then return to IDLE; no new request accepted before.
REQ-026 SHALL achieve, with zero-wait slave and resp_ready=1, resp_valid 3 cycles after load accept and 3 cycles after store accept (bvalid one cycle after w/aw handshake).
REQ-027 SHALL never assert arvalid and awvalid simultaneously; one outstanding transaction maximum.

Reset
REQ-028 SHALL on rst go IDLE next edge, clearing all valids/readies outputs to 0 except req_ready=1, resp_rdata=0, resp_err=0, addresses/wdata/wstrb=0.
REQ-029 SHALL on rst mid-transaction abandon it (no completion response emitted), regardless of pending slave handshakes.

Configuration
REQ-030 SHALL, with LSU_MISALIGN_TRAP_EN defined, detect half at addr[0]=1 or word at addr[1:0]!=0 and go IDLE->RESP directly with resp_err=1, resp_rdata=0, no AXI activity.
REQ-031 SHALL, without LSU_MISALIGN_TRAP_EN, issue misaligned accesses normally using truncated lanes per REQ-021/REQ-023, resp_err from bus only.

Verification
REQ-032 SHALL verify lb at 0x80000003, rdata=0x80FF1234, unsigned=0 -> resp_rdata=0xFFFFFF80, araddr=0x80000000, err=0.
REQ-033 SHALL verify sh 0xABCD at 0x80000002 -> wstrb=4'b1100, wdata=0xABCD0000, awaddr=0x80000000, one resp_valid pulse.
REQ-034 SHALL verify store with wready 3 cycles after awready -> single B handshake, resp_valid only after bvalid.
REQ-035 SHALL verify lw with rresp=2'b10 and 5-cycle rvalid delay -> resp_err=1, resp_valid held while resp_ready low 4 cycles.
REQ-036 SHALL verify lw at 0x80000001 with macro -> resp_err=1, arvalid never high; rst during RD_DATA -> IDLE, no resp_valid.
